// File: rtl/scmp_pkg.sv
// Shared SC/MP board constants used by every board-side block.
package scmp_pkg;

  // Board oscillator frequency.
  localparam int CLK_HZ              = 50_000_000;

  // Debounce window is 2^DEB_BITS cycles (about 21 ms at CLK_HZ).
  localparam int DEB_BITS_DEFAULT    = 20;

  // Depth of the metastability synchroniser on raw board inputs (>= 2).
  localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/scmp_debounce.sv
// One board input channel: synchroniser, stability counter, debounced level
// and a registered one-cycle pulse on each debounced press.
module scmp_debounce
  import scmp_pkg::*;
#(
  parameter int DEB_BITS    = DEB_BITS_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT   // must be >= 2
) (
  input  logic clk_50m,
  input  logic rst,
  input  logic btn_n_i,     // raw, asynchronous, active-low
  output logic level_o,     // debounced pressed state, active-high
  output logic rise_o,      // registered pulse in the first cycle level_o reads 1
  output logic rise_set_o   // next-state of rise_o, lets the irq latch set on the same edge
);

  localparam logic [DEB_BITS-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DEB_BITS-1:0]    cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   sample;

  // Oldest synchroniser stage is the first metastability-safe copy.
  assign sample = ~sync_q[SYNC_STAGES-1];

  // Count consecutive cycles the sample disagrees with the level; the
  // all-ones count resolves to a level update, so the counter never wraps.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sample == level_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      level_d = sample;
      cnt_d   = '0;
      rise_d  = sample;
    end
  end

  // Synchroniser chain, counter, level and pulse registers; reset is the
  // idle (unpressed) state.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      sync_q  <= '1;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_n_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o    = level_q;
  assign rise_o     = rise_q;
  assign rise_set_o = rise_d;

endmodule

// File: rtl/scmp_sense_in.sv
// Board-side input conditioner: N_IN debounced channels plus a latched
// interrupt request for SC/MP sense A, held until the CPU acknowledges.
module scmp_sense_in
  import scmp_pkg::*;
#(
  parameter int N_IN        = 4,
  parameter int DEB_BITS    = DEB_BITS_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int IRQ_IDX     = 0
) (
  input  logic            clk_50m,
  input  logic            rst,
  input  logic [N_IN-1:0] btn_n,
  output logic [N_IN-1:0] level,
  output logic [N_IN-1:0] rise,
  output logic            irq_req,
  input  logic            irq_ack
);

  logic [N_IN-1:0] rise_set;
  logic            irq_req_q, irq_req_d;

  for (genvar g = 0; g < N_IN; g++) begin : g_ch
    scmp_debounce #(
      .DEB_BITS    (DEB_BITS),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_deb (
      .clk_50m    (clk_50m),
      .rst        (rst),
      .btn_n_i    (btn_n[g]),
      .level_o    (level[g]),
      .rise_o     (rise[g]),
      .rise_set_o (rise_set[g])
    );
  end

  // A press sets the request on the same edge as its rise pulse and keeps
  // it set while the pulse is visible, so an ack landing on either of those
  // edges cannot swallow the new event.
  always_comb begin
    irq_req_d = irq_req_q;
    if (rise_set[IRQ_IDX] || rise[IRQ_IDX]) begin
      irq_req_d = 1'b1;
    end else if (irq_ack) begin
      irq_req_d = 1'b0;
    end
  end

  // Interrupt request latch.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      irq_req_q <= 1'b0;
    end else begin
      irq_req_q <= irq_req_d;
    end
  end

  assign irq_req = irq_req_q;

endmodule
